// File: rtl/sad_err_sweep_ctrl.sv
// Error-evaluation sequencer for an exact/approximate SAD netlist pair.
// Drives one stimulus vector per cycle into both netlists, compares their
// outputs and accumulates error count, maximum, sum and worst-case vector.
// Stimulus is either an exhaustive count or a 16-bit Fibonacci LFSR.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | post-reset, waiting for start
// S_SWEEP | one vector evaluated per clock, statistics accumulating
// S_DONE  | statistics frozen, done high, waiting for the next start
module sad_err_sweep_ctrl #(
    parameter int NI = 10,
    parameter int NO = 3,
    parameter int CW = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             mode,
    input  logic [CW-1:0]    num_vec,
    input  logic [15:0]      seed,
    input  logic             abort,
    output logic [NI-1:0]    pi_o,
    input  logic [NO-1:0]    po_exact,
    input  logic [NO-1:0]    po_approx,
    output logic             busy,
    output logic             done,
    output logic [CW-1:0]    vec_cnt,
    output logic [CW-1:0]    err_cnt,
    output logic [NO-1:0]    err_max,
    output logic [CW+NO-1:0] err_sum,
    output logic [NI-1:0]    wce_vec
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SWEEP = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t           r_state;
    logic             r_mode;
    logic [CW-1:0]    r_num_vec;
    logic [15:0]      r_lfsr;
    logic [NI-1:0]    r_pi_o;
    logic             r_busy;
    logic             r_done;
    logic [CW-1:0]    r_vec_cnt;
    logic [CW-1:0]    r_err_cnt;
    logic [NO-1:0]    r_err_max;
    logic [CW+NO-1:0] r_err_sum;
    logic [NI-1:0]    r_wce_vec;

    logic [NO-1:0]    w_err;
    logic [15:0]      w_lfsr_next;
    logic [15:0]      w_seed_eff;
    logic [CW-1:0]    w_vec_inc;
    logic             w_last;

    // Absolute output difference, next LFSR value and end-of-sweep detect
    always_comb begin
        w_err       = (po_exact >= po_approx) ? (po_exact - po_approx)
                                              : (po_approx - po_exact);
        w_lfsr_next = {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
        // An all-zero seed would lock the LFSR, so it is replaced by 1
        w_seed_eff  = (seed == 16'h0000) ? 16'h0001 : seed;
        w_vec_inc   = r_vec_cnt + {{(CW-1){1'b0}}, 1'b1};
        w_last      = r_mode ? (w_vec_inc == r_num_vec) : (r_pi_o == {NI{1'b1}});
    end

    // Sequencer FSM with registered stimulus, status and statistics
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_mode    <= 1'b0;
            r_num_vec <= '0;
            r_lfsr    <= '0;
            r_pi_o    <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_vec_cnt <= '0;
            r_err_cnt <= '0;
            r_err_max <= '0;
            r_err_sum <= '0;
            r_wce_vec <= '0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_vec_cnt <= '0;
                        r_err_cnt <= '0;
                        r_err_max <= '0;
                        r_err_sum <= '0;
                        r_wce_vec <= '0;
                        r_mode    <= mode;
                        r_num_vec <= num_vec;
                        if (mode) begin
                            r_lfsr <= w_seed_eff;
                            r_pi_o <= w_seed_eff[NI-1:0];
                        end else begin
                            r_pi_o <= '0;
                        end
                        if (mode && (num_vec == '0)) begin
                            r_state <= S_DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= S_SWEEP;
                            r_busy  <= 1'b1;
                            r_done  <= 1'b0;
                        end
                    end
                end
                S_SWEEP: begin
                    if (abort) begin
                        // Current vector is dropped; statistics freeze as-is
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_vec_cnt <= w_vec_inc;
                        if (w_err != '0) begin
                            r_err_cnt <= r_err_cnt + {{(CW-1){1'b0}}, 1'b1};
                            r_err_sum <= r_err_sum + {{CW{1'b0}}, w_err};
                        end
                        // Strict compare so ties keep the earliest vector
                        if (w_err > r_err_max) begin
                            r_err_max <= w_err;
                            r_wce_vec <= r_pi_o;
                        end
                        if (r_mode) begin
                            r_lfsr <= w_lfsr_next;
                            r_pi_o <= w_lfsr_next[NI-1:0];
                        end else begin
                            r_pi_o <= r_pi_o + {{(NI-1){1'b0}}, 1'b1};
                        end
                        if (w_last) begin
                            r_state <= S_DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign pi_o    = r_pi_o;
    assign busy    = r_busy;
    assign done    = r_done;
    assign vec_cnt = r_vec_cnt;
    assign err_cnt = r_err_cnt;
    assign err_max = r_err_max;
    assign err_sum = r_err_sum;
    assign wce_vec = r_wce_vec;

endmodule

// File: tb/tb_sad_err_sweep_ctrl.sv
// Bench for sad_err_sweep_ctrl: directed record table, randomized runs
// against a vector-list reference model, and a mid-sweep reset sequence.
module tb_sad_err_sweep_ctrl;

    localparam int NI = 10;
    localparam int NO = 3;
    localparam int CW = 16;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic             mode = 1'b0;
    logic [CW-1:0]    num_vec = '0;
    logic [15:0]      seed = '0;
    logic             abort = 1'b0;
    logic [NI-1:0]    pi_o;
    logic [NO-1:0]    po_exact;
    logic [NO-1:0]    po_approx;
    logic             busy;
    logic             done;
    logic [CW-1:0]    vec_cnt;
    logic [CW-1:0]    err_cnt;
    logic [NO-1:0]    err_max;
    logic [CW+NO-1:0] err_sum;
    logic [NI-1:0]    wce_vec;

    int checks = 0;
    int errors = 0;
    int g_kind = 0;
    logic [2:0] tab_ex [1024];
    logic [2:0] tab_ap [1024];

    always #5 clk = ~clk;

    sad_err_sweep_ctrl #(.NI(NI), .NO(NO), .CW(CW)) dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .num_vec(num_vec),
        .seed(seed), .abort(abort), .pi_o(pi_o), .po_exact(po_exact),
        .po_approx(po_approx), .busy(busy), .done(done), .vec_cnt(vec_cnt),
        .err_cnt(err_cnt), .err_max(err_max), .err_sum(err_sum), .wce_vec(wce_vec)
    );

    // Netlist pair stand-ins: 0 identical, 1 approx=0, 2 LSB flipped, 3 random tables
    function automatic int f_ex(int kind, int v);
        return (kind == 3) ? int'(tab_ex[v % 1024]) : (v % 8);
    endfunction

    function automatic int f_ap(int kind, int v);
        case (kind)
            0:       return v % 8;
            1:       return 0;
            2:       return (v % 8) ^ 1;
            default: return int'(tab_ap[v % 1024]);
        endcase
    endfunction

    assign po_exact  = 3'(f_ex(g_kind, int'(pi_o)));
    assign po_approx = 3'(f_ap(g_kind, int'(pi_o)));

    typedef struct {
        int         kind;
        bit         md;
        logic [15:0] sd;
        int         nv;
        int         abort_at;
        bit         poke;
        int         e_vec, e_cnt, e_max, e_sum, e_wce, e_cyc;
    } rec_t;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int lfsr_adv(int s);
        int fb;
        fb = ((s >> 15) ^ (s >> 13) ^ (s >> 12) ^ (s >> 10)) & 1;
        return ((s * 2) & 16'hFFFF) | fb;
    endfunction

    function automatic int first_state(logic [15:0] sd);
        return (sd == 16'h0000) ? 1 : int'(sd);
    endfunction

    // Reference: list the vectors that get evaluated, then fold statistics
    task automatic model(inout rec_t r);
        int n, nev, s, v, e;
        n = r.md ? r.nv : 1024;
        nev = (r.abort_at != 0) ? r.abort_at - 1 : n;
        r.e_cyc = (r.abort_at != 0) ? r.abort_at : n;
        r.e_vec = 0; r.e_cnt = 0; r.e_max = 0; r.e_sum = 0; r.e_wce = 0;
        s = first_state(r.sd);
        for (int k = 0; k < nev; k++) begin
            v = r.md ? (s % 1024) : k;
            e = f_ex(r.kind, v) - f_ap(r.kind, v);
            if (e < 0) e = -e;
            r.e_vec++;
            if (e != 0) begin r.e_cnt++; r.e_sum += e; end
            if (e > r.e_max) begin r.e_max = e; r.e_wce = v; end
            s = lfsr_adv(s);
        end
    endtask

    task automatic check_stats(input string tag, input rec_t r);
        chk({tag, " vec_cnt"}, int'(vec_cnt), r.e_vec);
        chk({tag, " err_cnt"}, int'(err_cnt), r.e_cnt);
        chk({tag, " err_max"}, int'(err_max), r.e_max);
        chk({tag, " err_sum"}, int'(err_sum), r.e_sum);
        chk({tag, " wce_vec"}, int'(wce_vec), r.e_wce);
    endtask

    task automatic do_run(input string tag, input rec_t r);
        int cyc, s, cur;
        @(negedge clk);
        g_kind = r.kind; mode = r.md; seed = r.sd; num_vec = CW'(r.nv); start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        s = first_state(r.sd);
        cyc = 0;
        while (cyc < 1100) begin
            if (done) break;
            cur = r.md ? (s % 1024) : cyc;
            if (busy !== 1'b1 || int'(pi_o) != cur) begin
                chk({tag, " busy"}, int'(busy), 1);
                chk({tag, " pi_o"}, int'(pi_o), cur);
            end
            if (r.abort_at != 0 && cyc + 1 == r.abort_at) abort = 1'b1;
            if (r.poke && cyc == 3) begin
                start = 1'b1; mode = 1'b1; num_vec = '0;
            end
            @(negedge clk);
            abort = 1'b0; start = 1'b0; mode = r.md; num_vec = CW'(r.nv);
            s = lfsr_adv(s);
            cyc++;
        end
        chk({tag, " done_cycles"}, cyc, r.e_cyc);
        chk({tag, " busy_done"}, int'(busy), 0);
        check_stats(tag, r);
        repeat (3) @(negedge clk);
        chk({tag, " done_hold"}, int'(done), 1);
        check_stats({tag, " hold"}, r);
    endtask

    rec_t tbl [8];

    initial begin
        rec_t r;
        for (int i = 0; i < 1024; i++) begin
            tab_ex[i] = 3'($urandom_range(0, 7));
            tab_ap[i] = ($urandom_range(0, 1) == 0) ? tab_ex[i] : 3'($urandom_range(0, 7));
        end

        //         kind md sd   nv abort poke vec   cnt  max sum   wce cyc
        tbl[0] = '{0, 0, 16'h0, 0, 0,  0, 1024, 0,    0, 0,    0, 1024};
        tbl[1] = '{1, 0, 16'h0, 0, 0,  0, 1024, 896,  7, 3584, 7, 1024};
        tbl[2] = '{2, 0, 16'h0, 0, 0,  0, 1024, 1024, 1, 1024, 0, 1024};
        tbl[3] = '{0, 1, 16'h0, 4, 0,  0, 4,    0,    0, 0,    0, 4};
        tbl[4] = '{2, 1, 16'h0, 4, 0,  0, 4,    4,    1, 4,    1, 4};
        tbl[5] = '{1, 1, 16'h5, 0, 0,  0, 0,    0,    0, 0,    0, 0};
        tbl[6] = '{1, 0, 16'h0, 0, 10, 1, 9,    7,    7, 28,   7, 10};
        tbl[7] = '{0, 0, 16'h0, 0, 0,  0, 1024, 0,    0, 0,    0, 1024};

        repeat (3) @(negedge clk);
        chk("reset busy", int'(busy), 0);
        chk("reset done", int'(done), 0);
        chk("reset pi_o", int'(pi_o), 0);
        r = '{0, 0, 16'h0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        check_stats("reset", r);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) do_run($sformatf("tbl%0d", i), tbl[i]);

        // Random runs: random netlist tables, mixed modes, seeds and aborts
        for (int i = 0; i < 8; i++) begin
            r.kind = 3;
            r.md = (i < 2) ? 1'b0 : 1'b1;
            r.sd = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
            r.nv = $urandom_range(0, 300);
            r.poke = 1'($urandom_range(0, 1));
            r.abort_at = 0;
            if ($urandom_range(0, 2) == 0) begin
                if (!r.md) r.abort_at = $urandom_range(1, 1024);
                else if (r.nv > 0) r.abort_at = $urandom_range(1, r.nv);
            end
            if (r.md && r.nv <= 3) r.poke = 1'b0;
            model(r);
            do_run($sformatf("rnd%0d", i), r);
        end

        // Reset in the middle of an exhaustive sweep, then a cold rerun
        @(negedge clk);
        g_kind = 1; mode = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (500) @(negedge clk);
        chk("midrst vec_cnt before", int'(vec_cnt), 500);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst busy", int'(busy), 0);
        chk("midrst done", int'(done), 0);
        chk("midrst pi_o", int'(pi_o), 0);
        r = '{0, 0, 16'h0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        check_stats("midrst", r);
        repeat (2) @(negedge clk);
        chk("midrst idle busy", int'(busy), 0);
        do_run("after_rst", tbl[1]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sad_err_sweep_ctrl.md
Name: sad_err_sweep_ctrl

Overview:
- Sequencer for error evaluation of approximate SAD circuits.
- Drives a shared stimulus vector into an exact and an approximate combinational SAD netlist (10-in / 3-out class), compares their outputs every cycle, and accumulates error statistics.
- Two stimulus modes: exhaustive sweep or LFSR pseudo-random sampling.
- Sits between the netlist pair and the evaluation-result readout.

Parameters:
- NI, 10, stimulus width (netlist primary inputs).
- NO, 3, netlist output width.
- CW, 16, vector-count width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  begin evaluation; accepted only when busy=0
- mode  in  1  0 = exhaustive, 1 = random (LFSR)
- num_vec  in  CW  vector count for random mode; sampled at start
- seed  in  16  LFSR seed; sampled at start
- abort  in  1  terminate a sweep early
- pi_o  out  NI  registered stimulus to both netlists
- po_exact  in  NO  exact netlist output, combinational function of pi_o
- po_approx  in  NO  approximate netlist output, combinational function of pi_o
- busy  out  1  high in SWEEP
- done  out  1  level, high in DONE until the next accepted start
- vec_cnt  out  CW  vectors evaluated
- err_cnt  out  CW  vectors with po_exact != po_approx
- err_max  out  NO  maximum |po_exact - po_approx|
- err_sum  out  CW+NO  sum of |po_exact - po_approx|
- wce_vec  out  NI  first vector reaching err_max

Behaviour:
- **Reset:** On reset, state=IDLE and all outputs are 0, including pi_o, lfsr, done and busy. Reset has priority over every other input, including mid-sweep.
- **States:** IDLE, SWEEP, DONE. Encoding is free.
- **Start (IDLE or DONE, start=1, edge t0):**
  - Clear vec_cnt, err_cnt, err_max, err_sum and wce_vec; clear done.
  - Latch mode and num_vec.
  - mode=0: pi_o <= 0.
  - mode=1: lfsr <= (seed==0 ? 16'h0001 : seed), and pi_o <= that value's [NI-1:0].
  - mode=1 with num_vec=0: go straight to DONE with all statistics 0. done is visible after t0.
  - Otherwise go to SWEEP.
- **start while busy:** Ignored.
- **SWEEP, each edge, abort=0:**
  - Compute e = |po_exact - po_approx| as unsigned NO-bit.
  - vec_cnt += 1.
  - If e != 0: err_cnt += 1 and err_sum += e (zero-extended).
  - If e > err_max (strict): err_max <= e and wce_vec <= pi_o. Ties keep the earlier vector.
  - Advance the stimulus:
    - mode=0: pi_o <= pi_o + 1.
    - mode=1: lfsr <= {lfsr[14:0], lfsr[15]^lfsr[13]^lfsr[12]^lfsr[10]} and pi_o <= next lfsr[NI-1:0].
- **Termination:** The last vector is evaluated, then state goes to DONE on the same edge.
  - mode=0: pi_o == all-ones, i.e. 2^NI vectors.
  - mode=1: vec_cnt+1 == num_vec.
  - pi_o may advance or wrap on the terminating edge; its value in DONE is don't-care.
- **Latency:** busy rises after t0 and falls after edge t0+N. done rises after edge t0+N, where N is the vector count.
- **Abort in SWEEP:** Go to DONE. The current vector is NOT counted and the statistics freeze. Abort has priority over termination on the same edge. Abort outside SWEEP is ignored.
- **DONE:** Outputs are held stable until the next accepted start or reset.
- **Counter wrap:** No saturation is needed. Sizing guarantees no overflow: err_sum ≤ (2^CW-1)·(2^NO-1).

Test Plan:
1. Exhaustive, po_approx tied to po_exact (po_exact=pi_o[2:0]) -> done exactly 1024 cycles after the start edge; vec_cnt=1024, err_cnt=0, err_max=0, err_sum=0, wce_vec=0.
2. Exhaustive, po_exact=pi_o[2:0], po_approx=0 -> vec_cnt=1024, err_cnt=896, err_max=7, err_sum=3584, wce_vec=10'h007.
3. Exhaustive, po_approx=po_exact^3'b001 -> err_cnt=1024, err_max=1, err_sum=1024, wce_vec=10'h000.
4. Random, seed=0, num_vec=4 -> first pi_o=10'h001, next pi_o=10'h002, and the LFSR sequence matches a reference model; vec_cnt=4 and done after 4 cycles. With num_vec=0 -> done on the cycle after start, all statistics 0, busy never high.
5. Exhaustive, abort asserted at the 10th SWEEP edge -> vec_cnt=9 and done=1. start pulses during SWEEP are ignored. A second start from DONE clears the statistics and reruns scenario 1's result.
6. Reset asserted mid-sweep (vec_cnt=500) -> next cycle state=IDLE and all outputs 0. A subsequent start behaves as from cold.
